// File: rtl/fifo_2_axis_packer.sv
// ---------------------------------------------------------------------------
// fifo_2_axis_packer
//
// Pops words from a first-word-fall-through FIFO and packs
// RATIO = AXIS_DATA_WIDTH / FIFO_DATA_WIDTH consecutive words into one
// AXI-Stream beat. Word 0 of a beat goes in lane 0 (little-endian packing).
// A beat is closed early when the FIFO flags the head word as the last word
// of a packet. The beat is presented from a registered output stage.
//
// Optional feature macro: FIFO_2_AXIS_SOF_EN
//   defined   : o_axis_tuser marks the first beat after reset and the first
//               beat after each tlast beat (start of frame).
//   undefined : o_axis_tuser is tied low and no start-of-frame state exists.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_fifo_data      FIFO head word (valid while i_fifo_not_empty)
//   o_fifo_r_stb     pop strobe (combinational)
//   i_fifo_not_empty FIFO head valid
//   i_fifo_last      head word is the last word of a packet
//   o_axis_tuser     start of frame
//   o_axis_tdata     packed beat
//   o_axis_tkeep     byte enables of the filled lanes
//   o_axis_tvalid    beat valid
//   i_axis_tready    downstream ready
//   o_axis_tlast     last beat of a packet
// ---------------------------------------------------------------------------
module fifo_2_axis_packer #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int AXIS_DATA_WIDTH = 128
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [FIFO_DATA_WIDTH-1:0]   i_fifo_data,
  output logic                         o_fifo_r_stb,
  input  logic                         i_fifo_not_empty,
  input  logic                         i_fifo_last,
  output logic                         o_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]   o_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] o_axis_tkeep,
  output logic                         o_axis_tvalid,
  input  logic                         i_axis_tready,
  output logic                         o_axis_tlast
);

  localparam int RATIO      = AXIS_DATA_WIDTH / FIFO_DATA_WIDTH;
  localparam int IDX_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LANE_BYTES = FIFO_DATA_WIDTH / 8;

  // Lane index of the next word within the beat being assembled.
  logic [IDX_W-1:0] idx;

  // Pack register. Only lanes 0..RATIO-2 are ever written; the top lane is
  // always filled straight from the head word by the completing pop.
  logic [RATIO-1:0][FIFO_DATA_WIDTH-1:0] pack;

  logic completing;
  logic pop;
  logic load;
  logic beat_user;

  logic [RATIO-1:0][FIFO_DATA_WIDTH-1:0] merged_data;
  logic [RATIO-1:0][LANE_BYTES-1:0]      merged_keep;

  logic                         out_valid;
  logic [AXIS_DATA_WIDTH-1:0]   out_data;
  logic [AXIS_DATA_WIDTH/8-1:0] out_keep;
  logic                         out_last;
  logic                         out_user;

  // A completing word closes the beat and must land in the output stage, so
  // it may only pop when that stage is empty or being drained this cycle.
  // Non-completing words only touch the pack register and always pop.
  // The reset term keeps the strobe low while the block is held in reset.
  always_comb begin
    completing = (idx == IDX_W'(RATIO - 1)) | i_fifo_last;
    pop        = i_rst_n & i_fifo_not_empty &
                 (~completing | ~out_valid | i_axis_tready);
    load       = pop & completing;
  end

  assign o_fifo_r_stb = pop;

  // Beat image: stored lanes below idx, head word at idx, zero above.
  always_comb begin
    merged_data = '0;
    merged_keep = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (IDX_W'(k) < idx) begin
        merged_data[k] = pack[k];
        merged_keep[k] = '1;
      end else if (IDX_W'(k) == idx) begin
        merged_data[k] = i_fifo_data;
        merged_keep[k] = '1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx  <= '0;
      pack <= '0;
    end else if (pop) begin
      if (completing) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
        for (int unsigned k = 0; k < RATIO; k++) begin
          if (IDX_W'(k) == idx) begin
            pack[k] <= i_fifo_data;
          end
        end
      end
    end
  end

`ifdef FIFO_2_AXIS_SOF_EN
  // Set after reset and after every tlast beat; cleared by a non-last beat.
  logic sof;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sof <= 1'b1;
    end else if (load) begin
      sof <= i_fifo_last;
    end
  end

  assign beat_user = sof;
`else
  assign beat_user = 1'b0;
`endif

  // A load wins over the handshake clear, which keeps beats back-to-back.
  // Without a load the stage holds while tvalid & !tready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= merged_data;
      out_keep  <= merged_keep;
      out_last  <= i_fifo_last;
      out_user  <= beat_user;
    end else if (i_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign o_axis_tvalid = out_valid;
  assign o_axis_tdata  = out_data;
  assign o_axis_tkeep  = out_keep;
  assign o_axis_tlast  = out_last;
  assign o_axis_tuser  = out_user;

endmodule

// File: tb/tb_fifo_2_axis_packer.sv
// ---------------------------------------------------------------------------
// Testbench for fifo_2_axis_packer (32-bit FIFO words, 128-bit beats).
// A queue stands in for the FWFT FIFO; expected beats are pushed to a
// scoreboard as words are queued and compared as beats are accepted.
// ---------------------------------------------------------------------------
module tb_fifo_2_axis_packer;

`ifdef FIFO_2_AXIS_SOF_EN
  localparam logic SOF = 1'b1;
`else
  localparam logic SOF = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [31:0]  fifo_data;
  logic         fifo_r_stb;
  logic         fifo_not_empty;
  logic         fifo_last;
  logic         axis_tuser;
  logic [127:0] axis_tdata;
  logic [15:0]  axis_tkeep;
  logic         axis_tvalid;
  logic         axis_tready;
  logic         axis_tlast;

  fifo_2_axis_packer #(
    .FIFO_DATA_WIDTH (32),
    .AXIS_DATA_WIDTH (128)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_fifo_data      (fifo_data),
    .o_fifo_r_stb     (fifo_r_stb),
    .i_fifo_not_empty (fifo_not_empty),
    .i_fifo_last      (fifo_last),
    .o_axis_tuser     (axis_tuser),
    .o_axis_tdata     (axis_tdata),
    .o_axis_tkeep     (axis_tkeep),
    .o_axis_tvalid    (axis_tvalid),
    .i_axis_tready    (axis_tready),
    .o_axis_tlast     (axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         user;
  } beat_t;

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][31:0]  w;
    logic              lst;
    logic [127:0]      tdata;
    logic [15:0]       tkeep;
    logic              tlast;
    logic              tuser;
  } vec_t;

  word_t fq[$];
  beat_t exp_q[$];

  int   checks;
  int   errors;
  int   pops;
  int   beats;
  logic exp_sof;
  logic s_stb;
  logic s_valid;
  logic s_pop_last;

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, want);
    end
  endtask

  task automatic refresh();
    if (fq.size() > 0) begin
      fifo_data      = fq[0].data;
      fifo_last      = fq[0].last;
      fifo_not_empty = 1'b1;
    end else begin
      fifo_data      = '0;
      fifo_last      = 1'b0;
      fifo_not_empty = 1'b0;
    end
  endtask

  // Called at a falling edge: present the FIFO head, sample, score, and
  // retire whatever the next rising edge will consume.
  task automatic step();
    beat_t e;
    word_t w;
    refresh();
    #1;
    s_stb      = fifo_r_stb;
    s_valid    = axis_tvalid;
    s_pop_last = fifo_r_stb && (fq.size() > 0) && fq[0].last;
    if (axis_tvalid && axis_tready) begin
      beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat_tdata", axis_tdata, e.data);
        check("beat_tkeep", 128'(axis_tkeep), 128'(e.keep));
        check("beat_tlast", 128'(axis_tlast), 128'(e.last));
        check("beat_tuser", 128'(axis_tuser), 128'(e.user));
      end
    end
    if (fifo_r_stb) begin
      if (fq.size() > 0) begin
        w = fq.pop_front();
        pops++;
      end else begin
        check("pop_from_empty", 128'(1), 128'(0));
      end
    end
    @(negedge clk);
  endtask

  // Queue n words base+i; the reference packer closes a beat every 4 words
  // or on the packet's last word.
  task automatic push_pkt(input int n, input logic [31:0] base,
                          input logic last_end);
    logic [127:0] acc;
    logic [15:0]  keep;
    int           lane;
    word_t        w;
    beat_t        b;
    acc  = '0;
    keep = '0;
    lane = 0;
    for (int i = 0; i < n; i++) begin
      w.data = base + 32'(i);
      w.last = last_end && (i == n - 1);
      fq.push_back(w);
      acc[lane*32 +: 32] = w.data;
      keep[lane*4 +: 4]  = 4'hF;
      if (lane == 3 || w.last) begin
        b.data = acc;
        b.keep = keep;
        b.last = w.last;
        b.user = SOF & exp_sof;
        exp_q.push_back(b);
        exp_sof = w.last;
        acc  = '0;
        keep = '0;
        lane = 0;
      end else begin
        lane++;
      end
    end
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while ((exp_q.size() > 0 || fq.size() > 0 || axis_tvalid) && c < bound) begin
      step();
      c++;
    end
    check("drain_done", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_tvalid", 128'(axis_tvalid), 128'(0));
    check("rst_tdata", axis_tdata, 128'(0));
    check("rst_tkeep", 128'(axis_tkeep), 128'(0));
    check("rst_tlast", 128'(axis_tlast), 128'(0));
    check("rst_tuser", 128'(axis_tuser), 128'(0));
    check("rst_stb", 128'(fifo_r_stb), 128'(0));
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int p0;
    int b0;
    int n_stb;
    beat_t b;
    word_t w;

    checks      = 0;
    errors      = 0;
    pops        = 0;
    beats       = 0;
    exp_sof     = 1'b1;
    rst_n       = 1'b0;
    axis_tready = 1'b0;

    vecs[0] = '{n: 3'd4, w: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                lst: 1'b1, tdata: 128'h44444444_33333333_22222222_11111111,
                tkeep: 16'hFFFF, tlast: 1'b1, tuser: 1'b1};
    vecs[1] = '{n: 3'd2, w: {32'h0, 32'h0, 32'h0000000B, 32'h0000000A},
                lst: 1'b1, tdata: 128'h0000000B_0000000A,
                tkeep: 16'h00FF, tlast: 1'b1, tuser: 1'b1};
    vecs[2] = '{n: 3'd1, w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                lst: 1'b1, tdata: 128'hDEADBEEF,
                tkeep: 16'h000F, tlast: 1'b1, tuser: 1'b1};
    vecs[3] = '{n: 3'd4, w: {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001},
                lst: 1'b0, tdata: 128'h00000004_00000003_00000002_00000001,
                tkeep: 16'hFFFF, tlast: 1'b0, tuser: 1'b1};
    vecs[4] = '{n: 3'd3, w: {32'h0, 32'h00000007, 32'h00000006, 32'h00000005},
                lst: 1'b1, tdata: 128'h00000007_00000006_00000005,
                tkeep: 16'h0FFF, tlast: 1'b1, tuser: 1'b0};
    vecs[5] = '{n: 3'd2, w: {32'h0, 32'h0, 32'hC0DE0002, 32'hC0DE0001},
                lst: 1'b1, tdata: 128'hC0DE0002_C0DE0001,
                tkeep: 16'h00FF, tlast: 1'b1, tuser: 1'b1};

    // Reset: outputs and pop strobe low even with a word waiting.
    @(negedge clk);
    w.data = 32'hFFFF0000;
    w.last = 1'b0;
    fq.push_back(w);
    for (int i = 0; i < 2; i++) begin
      refresh();
      #1;
      check_reset_outputs();
      @(negedge clk);
    end
    fq.delete();
    refresh();
    rst_n       = 1'b1;
    axis_tready = 1'b1;

    // Table of single-beat packets.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        w.data = vecs[v].w[i];
        w.last = vecs[v].lst && (i == int'(vecs[v].n) - 1);
        fq.push_back(w);
      end
      b.data = vecs[v].tdata;
      b.keep = vecs[v].tkeep;
      b.last = vecs[v].tlast;
      b.user = SOF & vecs[v].tuser;
      exp_q.push_back(b);
      exp_sof = vecs[v].tlast;
      drain(40);
    end

    // Latency: beat visible one cycle after its completing pop.
    push_pkt(4, 32'h50000000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_pop_last) break;
    end
    check("latency_pop_seen", 128'(s_pop_last), 128'(1));
    step();
    check("latency_valid", 128'(s_valid), 128'(1));
    drain(20);

    // Backpressure: 8-word packet, downstream stalled after beat 1 forms.
    axis_tready = 1'b0;
    p0 = pops;
    push_pkt(8, 32'h80000000, 1'b1);
    for (int c = 0; c < 10; c++) step();
    check("bp_pops", 128'(pops - p0), 128'(7));
    check("bp_stall_stb", 128'(s_stb), 128'(0));
    check("bp_held_valid", 128'(s_valid), 128'(1));
    axis_tready = 1'b1;
    step();
    check("bp_release_stb", 128'(s_stb), 128'(1));
    check("bp_first_taken", 128'(exp_q.size()), 128'(1));
    drain(20);

    // Streaming: 64 words back to back, 16 beats.
    b0 = beats;
    n_stb = 0;
    push_pkt(64, 32'h00001000, 1'b1);
    for (int c = 0; c < 64; c++) begin
      step();
      if (s_stb) n_stb++;
    end
    check("stream_stb_cycles", 128'(n_stb), 128'(64));
    drain(20);
    check("stream_beats", 128'(beats - b0), 128'(16));

    // Empty FIFO mid-beat, then reset drops the partial beat.
    push_pkt(2, 32'hBAD00000, 1'b0);
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      check("partial_wait_valid", 128'(s_valid), 128'(0));
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      refresh();
      #1;
      check_reset_outputs();
      @(negedge clk);
    end
    rst_n   = 1'b1;
    exp_sof = 1'b1;
    push_pkt(4, 32'hF00D0000, 1'b1);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
